uart_transceiver: RTL

//  Full-duplex UART with parametrised frame format and a 16x-oversampled receiver.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tick_gen.sv | 23 ++
 rtl/uart_transceiver.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and the baud divider helper for the UART.
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   // TxLoad holds an accepted byte until the next tick starts the start bit.
   typedef enum logic [2:0] {TxIdle, TxLoad, TxStart, TxData, TxParity, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud_rate,
                                            input int unsigned sample_ratio);
      return clk_freq / baud_rate / sample_ratio;
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running enable-tick generator: one-cycle pulse every DIV clocks.
module uart_tick_gen #(
   parameter int unsigned DIV = 651
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] count_q;

   assign tick = (count_q == CW'(DIV - 1));

   // Wrap at DIV-1 so the tick period is exactly DIV clocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    count_q <= '0;
      else if (tick) count_q <= '0;
      else           count_q <= count_q + 1'b1;
   end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: tick-paced transmitter and 16x-oversampled receiver with
// valid/ready byte interfaces and parity/frame/overrun status.
module uart_transceiver
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 100_000_000,
   parameter int unsigned BAUD_RATE    = 9600,
   parameter int unsigned SAMPLE_RATIO = 16,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   output logic                 txd,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun
);

   localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, SAMPLE_RATIO);
   localparam int unsigned CW  = $clog2(SAMPLE_RATIO);
   localparam logic [CW-1:0] LAST_TICK = CW'(SAMPLE_RATIO - 1);
   localparam logic [CW-1:0] PRE_LAST  = CW'(SAMPLE_RATIO - 2);
   localparam logic [CW-1:0] HALF_TICK = CW'(SAMPLE_RATIO / 2 - 1);
   localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic          ODD_PAR   = (PARITY == PARITY_ODD);

   logic tick;

   uart_tick_gen #(.DIV(DIV)) u_tick_gen (.clk(clk), .rst_n(rst_n), .tick(tick));

   // ---------------- transmitter ----------------
   tx_state_e            tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [3:0]           tx_idx_q, tx_idx_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_par_q, tx_par_d;
   logic                 txd_q, txd_d;

   assign tx_ready = (tx_state_q == TxIdle);
   assign txd      = txd_q;

   // TX state register; txd resets high so a mid-frame reset idles the line at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         txd_q      <= txd_d;
      end
   end

   // TX next state: each bit lasts SAMPLE_RATIO ticks, txd only changes on ticks.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      txd_d      = txd_q;
      unique case (tx_state_q)
         TxIdle: begin
            txd_d = 1'b1;
            if (tx_valid) begin
               tx_shift_d = tx_data;
               tx_par_d   = ODD_PAR ? ~^tx_data : ^tx_data;
               tx_state_d = TxLoad;
            end
         end
         TxLoad: begin
            if (tick) begin
               txd_d      = 1'b0;
               tx_cnt_d   = '0;
               tx_state_d = TxStart;
            end
         end
         default: begin
            if (tick) begin
               // Leave one tick early so a held tx_valid is loaded in time for the
               // next start bit to follow the stop bit without a gap.
               if (tx_state_q == TxStop && tx_idx_q == LAST_STOP && tx_cnt_q == PRE_LAST) begin
                  tx_state_d = TxIdle;
               end else if (tx_cnt_q != LAST_TICK) begin
                  tx_cnt_d = tx_cnt_q + 1'b1;
               end else begin
                  tx_cnt_d = '0;
                  case (tx_state_q)
                     TxStart: begin
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_idx_d   = '0;
                        tx_state_d = TxData;
                     end
                     TxData: begin
                        if (tx_idx_q != LAST_DATA) begin
                           txd_d      = tx_shift_q[0];
                           tx_shift_d = tx_shift_q >> 1;
                           tx_idx_d   = tx_idx_q + 1'b1;
                        end else if (PARITY != PARITY_NONE) begin
                           txd_d      = tx_par_q;
                           tx_state_d = TxParity;
                        end else begin
                           txd_d      = 1'b1;
                           tx_idx_d   = '0;
                           tx_state_d = TxStop;
                        end
                     end
                     TxParity: begin
                        txd_d      = 1'b1;
                        tx_idx_d   = '0;
                        tx_state_d = TxStop;
                     end
                     TxStop:  tx_idx_d = tx_idx_q + 1'b1;
                     default: ;
                  endcase
               end
            end
         end
      endcase
   end

   // ---------------- receiver ----------------
   rx_state_e            rx_state_q, rx_state_d;
   logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
   logic [3:0]           rx_idx_q, rx_idx_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_pbad_q, rx_pbad_d;
   logic                 rx_armed_q, rx_armed_d;
   logic                 rx_meta_q, rxd_s_q;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_ferr_q, rx_ferr_d;
   logic                 rx_ovr_q, rx_ovr_d;
   logic                 rx_done, rx_hs;

   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;
   assign rx_overrun    = rx_ovr_q;
   assign rx_hs         = rx_valid_q & rx_ready;

   // Two-flop synchroniser for the asynchronous rxd pin, idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rxd_s_q   <= 1'b1;
      end else begin
         rx_meta_q <= rxd;
         rxd_s_q   <= rx_meta_q;
      end
   end

   // RX state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_pbad_q  <= 1'b0;
         rx_armed_q <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_pbad_q  <= rx_pbad_d;
         rx_armed_q <= rx_armed_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

   // RX next state: mid-bit sampling on ticks, then delivery/overrun bookkeeping.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_pbad_d  = rx_pbad_q;
      rx_armed_d = rx_armed_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_ovr_d   = rx_ovr_q;
      rx_done    = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            // After a break the line must return high before a new start is accepted.
            if (rxd_s_q) rx_armed_d = 1'b1;
            if (tick && rx_armed_q && !rxd_s_q) begin
               rx_cnt_d   = '0;
               rx_state_d = RxStart;
            end
         end
         RxStart: begin
            if (tick) begin
               if (rx_cnt_q != HALF_TICK) begin
                  rx_cnt_d = rx_cnt_q + 1'b1;
               end else if (rxd_s_q) begin
                  rx_state_d = RxIdle;
               end else begin
                  rx_cnt_d   = '0;
                  rx_idx_d   = '0;
                  rx_state_d = RxData;
               end
            end
         end
         default: begin
            if (tick) begin
               if (rx_cnt_q != LAST_TICK) begin
                  rx_cnt_d = rx_cnt_q + 1'b1;
               end else begin
                  rx_cnt_d = '0;
                  case (rx_state_q)
                     RxData: begin
                        rx_shift_d = {rxd_s_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_idx_d   = rx_idx_q + 1'b1;
                        if (rx_idx_q == LAST_DATA) begin
                           rx_state_d = (PARITY != PARITY_NONE) ? RxParity : RxStop;
                        end
                     end
                     RxParity: begin
                        rx_pbad_d  = ((^rx_shift_q) ^ rxd_s_q) != ODD_PAR;
                        rx_state_d = RxStop;
                     end
                     RxStop: begin
                        rx_done    = 1'b1;
                        rx_armed_d = rxd_s_q;
                        rx_state_d = RxIdle;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase

      if (rx_done) begin
         rx_data_d  = rx_shift_q;
         rx_perr_d  = rx_pbad_q;
         rx_ferr_d  = ~rxd_s_q;
         rx_valid_d = 1'b1;
         rx_ovr_d   = rx_valid_q & ~rx_hs;
      end else if (rx_hs) begin
         rx_valid_d = 1'b0;
         rx_ovr_d   = 1'b0;
      end
   end

endmodule
